// File: rtl/uart_time_sender.sv
//------------------------------------------------------------------------------
// Module      : uart_time_sender
// Description : Serialises a snapshot of hour/min/sec as ASCII "HH:MM:SS[\r\n]"
//               one byte at a time through an external UART transmitter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_time_sender #(
    parameter int TIMEOUT   = 200000,
    parameter bit SEND_CRLF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       dropped
);

    localparam int               CNT_W        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]       LAST_IDX     = SEND_CRLF ? 4'd9 : 4'd7;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_LOAD      = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       index_q, index_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             tx_start_q, tx_start_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             dropped_q, dropped_d;
    logic [7:0]       cur_byte;

    function automatic logic [7:0] ascii_tens(input logic [5:0] v);
        return 8'h30 + {2'b00, v / 6'd10};
    endfunction

    function automatic logic [7:0] ascii_ones(input logic [5:0] v);
        return 8'h30 + {2'b00, v % 6'd10};
    endfunction

    always_comb begin
        case (index_q)
            4'd0:       cur_byte = ascii_tens({1'b0, hour_q});
            4'd1:       cur_byte = ascii_ones({1'b0, hour_q});
            4'd3:       cur_byte = ascii_tens(min_q);
            4'd4:       cur_byte = ascii_ones(min_q);
            4'd6:       cur_byte = ascii_tens(sec_q);
            4'd7:       cur_byte = ascii_ones(sec_q);
            4'd2, 4'd5: cur_byte = 8'h3A;
            4'd8:       cur_byte = 8'h0D;
            4'd9:       cur_byte = 8'h0A;
            default:    cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        cnt_d      = cnt_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        // Only IDLE accepts; a request in any other state is reported and lost.
        dropped_d  = send && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (send) begin
                    hour_d  = hour;
                    min_d   = min;
                    sec_d   = sec;
                    index_d = 4'd0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = cur_byte;
                    cnt_d      = '0;
                    state_d    = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    if (index_q == LAST_IDX) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        index_d = index_q + 4'd1;
                        state_d = S_LOAD;
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            index_q    <= 4'd0;
            cnt_q      <= '0;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            index_q    <= index_d;
            cnt_q      <= cnt_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            dropped_q  <= dropped_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign dropped  = dropped_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_time_sender.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_time_sender
// Description : Directed self-checking bench for uart_time_sender.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_uart_time_sender;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       send_a = 1'b0, send_b = 1'b0;
    logic [4:0] hour = 5'd0;
    logic [5:0] min = 6'd0, sec = 6'd0;
    logic       a_force_busy = 1'b0;
    logic       a_tx_busy;
    logic       a_tx_done = 1'b0, b_tx_done = 1'b0;
    logic       a_tx_start, a_busy, a_done, a_err, a_dropped;
    logic       b_tx_start, b_busy, b_done, b_err, b_dropped;
    logic [7:0] a_tx_data, b_tx_data;

    assign a_tx_busy = a_force_busy;

    uart_time_sender #(.TIMEOUT(100), .SEND_CRLF(1'b1)) dut_a (
        .clk(clk), .rst(rst), .send(send_a), .hour(hour), .min(min), .sec(sec),
        .tx_busy(a_tx_busy), .tx_done(a_tx_done), .tx_start(a_tx_start),
        .tx_data(a_tx_data), .busy(a_busy), .done(a_done), .err(a_err),
        .dropped(a_dropped)
    );

    uart_time_sender #(.TIMEOUT(100), .SEND_CRLF(1'b0)) dut_b (
        .clk(clk), .rst(rst), .send(send_b), .hour(hour), .min(min), .sec(sec),
        .tx_busy(1'b0), .tx_done(b_tx_done), .tx_start(b_tx_start),
        .tx_data(b_tx_data), .busy(b_busy), .done(b_done), .err(b_err),
        .dropped(b_dropped)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_msg [10] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36, 8'h0D, 8'h0A};
    logic [7:0] exp_b   [8]  = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h35};

    // UART model and event counters for dut_a: tx_done 20 cycles after each start.
    logic [7:0] bytes_a [$];
    int  cyc = 0, cnt_a = 0, n_starts_a = 0, n_done_a = 0, n_err_a = 0, n_drop_a = 0;
    int  stab_a = 0, withhold_a = 0, start_cyc_a = 0, err_cyc_a = 0;
    bit  inflight_a = 0, drop_last_a = 0, mdl_sent = 0;
    logic [7:0] held_a = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            a_tx_done = 1'b0;
            if (mdl_sent) begin
                send_a   = 1'b0;
                mdl_sent = 1'b0;
            end
            if (!rst) begin
                cnt_a      = 0;
                inflight_a = 0;
            end
            if (inflight_a && a_tx_data !== held_a) stab_a++;
            if (cnt_a > 0) begin
                cnt_a--;
                if (cnt_a == 0) begin
                    a_tx_done  = 1'b1;
                    inflight_a = 0;
                    if (drop_last_a && bytes_a.size() == 10) begin
                        send_a   = 1'b1;
                        mdl_sent = 1'b1;
                    end
                end
            end
            if (a_tx_start === 1'b1) begin
                bytes_a.push_back(a_tx_data);
                n_starts_a++;
                start_cyc_a = cyc;
                held_a      = a_tx_data;
                inflight_a  = 1;
                if (n_starts_a != withhold_a) cnt_a = 20;
            end
            if (a_done === 1'b1)    n_done_a++;
            if (a_err === 1'b1)     begin n_err_a++; err_cyc_a = cyc; end
            if (a_dropped === 1'b1) n_drop_a++;
        end
    end

    logic [7:0] bytes_b [$];
    int cnt_b = 0, n_done_b = 0;

    initial begin
        forever begin
            @(negedge clk);
            b_tx_done = 1'b0;
            if (cnt_b > 0) begin
                cnt_b--;
                if (cnt_b == 0) b_tx_done = 1'b1;
            end
            if (b_tx_start === 1'b1) begin
                bytes_b.push_back(b_tx_data);
                cnt_b = 20;
            end
            if (b_done === 1'b1) n_done_b++;
        end
    end

    task automatic clear_mon();
        @(posedge clk);
        bytes_a.delete();
        n_starts_a = 0; n_done_a = 0; n_err_a = 0; n_drop_a = 0; stab_a = 0;
    endtask

    task automatic pulse_send_a();
        @(negedge clk); send_a = 1'b1;
        @(negedge clk); send_a = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 500 && n_done_a == 0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic check_msg_a(input string name);
        tests++;
        if (bytes_a.size() != 10) begin
            fails++;
            $display("FAIL %s_len: got %0d bytes, expected 10", name, bytes_a.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                tests++;
                if (bytes_a[i] !== exp_msg[i]) begin
                    fails++;
                    $display("FAIL %s_byte%0d: got %02h expected %02h", name, i, bytes_a[i], exp_msg[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_tx_start, a_busy, a_done, a_err, a_dropped} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: got %05b expected 00000", {a_tx_start, a_busy, a_done, a_err, a_dropped});
        end
        tests++;
        if (a_tx_data !== 8'h00) begin
            fails++;
            $display("FAIL reset_tx_data: got %02h expected 00", a_tx_data);
        end
        tests++;
        if ({b_tx_start, b_busy, b_tx_data} !== 10'h0) begin
            fails++;
            $display("FAIL reset_b: got %03h expected 000", {b_tx_start, b_busy, b_tx_data});
        end
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_message();
        clear_mon();
        hour = 5'd12; min = 6'd34; sec = 6'd56;
        pulse_send_a();
        tests++;
        if ({a_busy, a_tx_start} !== 2'b10) begin
            fails++;
            $display("FAIL accept_busy: got busy,start=%02b expected 10", {a_busy, a_tx_start});
        end
        @(negedge clk);
        tests++;
        if (a_tx_start !== 1'b1 || a_tx_data !== 8'h31) begin
            fails++;
            $display("FAIL first_start: got start=%b data=%02h expected 1 31", a_tx_start, a_tx_data);
        end
        wait_done_a();
        check_msg_a("msg");
        tests++;
        if (n_done_a != 1 || n_err_a != 0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL msg_end: got done=%0d err=%0d busy=%b expected 1 0 0", n_done_a, n_err_a, a_busy);
        end
        tests++;
        if (stab_a != 0) begin
            fails++;
            $display("FAIL tx_data_stable: got %0d changes expected 0", stab_a);
        end
    endtask

    task automatic test_no_crlf();
        bytes_b.delete(); n_done_b = 0;
        hour = 5'd0; min = 6'd0; sec = 6'd5;
        @(negedge clk); send_b = 1'b1;
        @(negedge clk); send_b = 1'b0;
        for (int i = 0; i < 400 && n_done_b == 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (bytes_b.size() != 8) begin
            fails++;
            $display("FAIL nocrlf_len: got %0d bytes expected 8", bytes_b.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests++;
                if (bytes_b[i] !== exp_b[i]) begin
                    fails++;
                    $display("FAIL nocrlf_byte%0d: got %02h expected %02h", i, bytes_b[i], exp_b[i]);
                end
            end
        end
        tests++;
        if (n_done_b != 1 || b_busy !== 1'b0 || b_err !== 1'b0) begin
            fails++;
            $display("FAIL nocrlf_end: got done=%0d busy=%b expected 1 0", n_done_b, b_busy);
        end
    endtask

    task automatic test_busy_hold();
        clear_mon();
        hour = 5'd12; min = 6'd34; sec = 6'd56;
        a_force_busy = 1'b1;
        pulse_send_a();
        repeat (50) @(negedge clk);
        tests++;
        if (n_starts_a != 0 || a_busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_hold: got starts=%0d busy=%b expected 0 1", n_starts_a, a_busy);
        end
        a_force_busy = 1'b0;
        @(negedge clk);
        tests++;
        if (a_tx_start !== 1'b1) begin
            fails++;
            $display("FAIL busy_release_start: got %b expected 1", a_tx_start);
        end
        wait_done_a();
        check_msg_a("busy_msg");
    endtask

    task automatic test_timeout();
        clear_mon();
        withhold_a = 3;
        pulse_send_a();
        for (int i = 0; i < 600 && n_err_a == 0; i++) @(negedge clk);
        @(negedge clk);
        tests++;
        if (n_err_a != 1 || (err_cyc_a - start_cyc_a) != 100) begin
            fails++;
            $display("FAIL timeout_err: got errs=%0d delay=%0d expected 1 100", n_err_a, err_cyc_a - start_cyc_a);
        end
        tests++;
        if (n_done_a != 0 || a_busy !== 1'b0 || bytes_a.size() != 3) begin
            fails++;
            $display("FAIL timeout_state: got done=%0d busy=%b bytes=%0d expected 0 0 3", n_done_a, a_busy, bytes_a.size());
        end
        withhold_a = 0;
        clear_mon();
        pulse_send_a();
        wait_done_a();
        check_msg_a("after_timeout");
    endtask

    task automatic test_dropped();
        clear_mon();
        hour = 5'd12; min = 6'd34; sec = 6'd56;
        drop_last_a = 1;
        pulse_send_a();
        for (int i = 0; i < 400 && n_starts_a < 4; i++) @(negedge clk);
        @(negedge clk);
        hour = 5'd7; min = 6'd8; sec = 6'd9;
        send_a = 1'b1;
        @(negedge clk); send_a = 1'b0;
        wait_done_a();
        repeat (5) @(negedge clk);
        drop_last_a = 0;
        tests++;
        if (n_drop_a != 2 || n_done_a != 1) begin
            fails++;
            $display("FAIL dropped_count: got dropped=%0d done=%0d expected 2 1", n_drop_a, n_done_a);
        end
        tests++;
        if (n_starts_a != 10 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL dropped_no_restart: got starts=%0d busy=%b expected 10 0", n_starts_a, a_busy);
        end
        check_msg_a("dropped_msg");
        hour = 5'd12; min = 6'd34; sec = 6'd56;
    endtask

    task automatic test_reset_mid();
        clear_mon();
        pulse_send_a();
        for (int i = 0; i < 400 && n_starts_a < 5; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests++;
        if ({a_tx_start, a_tx_data, a_busy, a_done, a_err, a_dropped} !== 13'h0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got %04h expected 0000",
                     {a_tx_start, a_tx_data, a_busy, a_done, a_err, a_dropped});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (60) @(negedge clk);
        tests++;
        if (n_starts_a != 5 || n_done_a != 0 || n_err_a != 0 || a_busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got starts=%0d done=%0d err=%0d busy=%b expected 5 0 0 0",
                     n_starts_a, n_done_a, n_err_a, a_busy);
        end
        clear_mon();
        pulse_send_a();
        wait_done_a();
        check_msg_a("post_reset");
    endtask

    initial begin
        test_reset();
        test_message();
        test_no_crlf();
        test_busy_hold();
        test_timeout();
        test_dropped();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
